// File: rtl/fetch_pkg.sv
// Shared types and field constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int OPCODE_MSB  = 7;
  localparam int OPCODE_LSB  = 4;
  localparam int OPERAND_MSB = 3;
  localparam int OPERAND_LSB = 0;

endpackage

// File: rtl/rom_fetch_unit_program_counter.sv
// Program counter: load beats increment; wrap pulses the cycle after a 0x..F -> 0 step.
// Single-cycle update, no backpressure of its own.
module program_counter #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc   <= RESET_PC;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        pc <= load_addr;
      end else if (inc) begin
        pc   <= pc + ADDR_W'(1);
        wrap <= &pc;
      end
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Fetch stage: drives ROM address from PC, registers returned byte; first instr 2 edges after en/load,
// then 1/cycle. valid/ready handshake: instr and instr_pc are held while ready is low.
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] direccion,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              pc_wrap
);

  fetch_state_t      state, state_nxt;
  logic              pc_load;
  logic              capture;
  logic [ADDR_W-1:0] pc;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (pc_load),
    .load_addr (load_addr),
    .inc       (capture),
    .pc        (pc),
    .wrap      (pc_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        instr    <= rom_data;
        instr_pc <= pc;
      end
    end
  end

  // A load always wins; in HOLD it either retires (ready=1) or flushes the held instruction.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        pc_load = load;
        if (en) state_nxt = FETCH;
      end
      FETCH: begin
        if (load) begin
          pc_load   = 1'b1;
          state_nxt = en ? FETCH : IDLE;
        end else if (!en) begin
          state_nxt = IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (load) begin
          pc_load   = 1'b1;
          state_nxt = en ? FETCH : IDLE;
        end else if (instr_ready) begin
          if (en) capture = 1'b1;
          else    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign direccion   = pc;
  assign instr_valid = (state == HOLD);
  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign operand     = instr[OPERAND_MSB:OPERAND_LSB];

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed scenarios plus random en/ready/load traffic
// against an in-order address scoreboard and a ROM model mem[i] = i + 0x10.
module tb_rom_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_addr = '0;
  logic [11:0] direccion;
  logic [7:0]  rom_data;
  logic [7:0]  instr;
  logic [3:0]  opcode;
  logic [3:0]  operand;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_wrap;

  always #5 clk = ~clk;

  rom_fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .load        (load),
    .load_addr   (load_addr),
    .direccion   (direccion),
    .rom_data    (rom_data),
    .instr       (instr),
    .opcode      (opcode),
    .operand     (operand),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_wrap     (pc_wrap)
  );

  function automatic logic [7:0] rom_val(input logic [11:0] a);
    logic [11:0] s;
    s = a + 12'h010;
    return s[7:0];
  endfunction

  assign rom_data = rom_val(direccion);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: instructions must arrive in address order from the last jump target.
  logic [11:0] exp_addr = 12'h000;
  int          hs_count = 0;
  logic        stalled = 1'b0;
  logic [7:0]  held_instr;
  logic [11:0] held_pc;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (stalled) begin
        check("stall_valid", instr_valid, 1'b1);
        check("stall_instr", instr, held_instr);
        check("stall_pc", instr_pc, held_pc);
      end
      stalled    = instr_valid && !instr_ready && !load;
      held_instr = instr;
      held_pc    = instr_pc;
      if (instr_valid && instr_ready) begin
        check("hs_pc", instr_pc, exp_addr);
        check("hs_data", instr, rom_val(exp_addr));
        check("hs_fields", {opcode, operand}, rom_val(exp_addr));
        exp_addr = exp_addr + 12'h001;
        hs_count++;
      end
      if (load) exp_addr = load_addr;
    end
  end

  always @(negedge reset_n) begin
    exp_addr = 12'h000;
    stalled  = 1'b0;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_instr"}, instr, 8'h00);
    check({tag, "_instr_pc"}, instr_pc, 12'h000);
    check({tag, "_direccion"}, direccion, 12'h000);
    check({tag, "_pc_wrap"}, pc_wrap, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int exp_edges);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 20);
    check(name, n, exp_edges);
  endtask

  initial begin
    logic [11:0] keep;
    int          wraps;

    repeat (2) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Streaming from reset
    en = 1'b1;
    instr_ready = 1'b1;
    wait_valid("first_valid_latency", 2);
    for (int i = 0; i < 3; i++) begin
      check("stream_valid", instr_valid, 1'b1);
      check("stream_instr", instr, 8'h10 + 8'(i));
      check("stream_pc", instr_pc, 12'(i));
      tick();
    end

    // Backpressure on 0x13
    check("bp_start_instr", instr, 8'h13);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_instr", instr, 8'h13);
      check("bp_pc", instr_pc, 12'h003);
      check("bp_addr", direccion, 12'h004);
    end
    instr_ready = 1'b1;
    tick();
    check("bp_release_instr", instr, 8'h14);
    check("bp_release_pc", instr_pc, 12'h004);

    // Jump with the held instruction flushed
    instr_ready = 1'b0;
    load = 1'b1;
    load_addr = 12'h200;
    tick();
    load = 1'b0;
    check("jmp_gap_valid", instr_valid, 1'b0);
    check("jmp_gap_addr", direccion, 12'h200);
    tick();
    check("jmp_valid", instr_valid, 1'b1);
    check("jmp_instr", instr, rom_val(12'h200));
    check("jmp_pc", instr_pc, 12'h200);
    instr_ready = 1'b1;

    // Wrap through 0xFFF
    load = 1'b1;
    load_addr = 12'hFFE;
    tick();
    load = 1'b0;
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pc_wrap) wraps++;
    end
    check("wrap_pulse_count", wraps, 1);

    // Drop en in HOLD with ready high
    keep = exp_addr + 12'h001;
    en = 1'b0;
    tick();
    check("idle_valid", instr_valid, 1'b0);
    check("idle_addr", direccion, keep);
    repeat (3) tick();
    check("idle_hold_valid", instr_valid, 1'b0);
    check("idle_hold_addr", direccion, keep);
    en = 1'b1;
    wait_valid("resume_latency", 2);
    check("resume_pc", instr_pc, keep);
    repeat (4) tick();

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #1;
    reset_n = 1'b1;
    wait_valid("rst_restart_latency", 2);
    check("rst_restart_pc", instr_pc, 12'h000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      en          = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      load        = ($urandom_range(0, 19) == 0);
      load_addr   = 12'($urandom);
    end
    tick();
    load = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    check("handshake_volume", (hs_count > 500), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
